// File: rtl/mini_cpu_param.sv
// mini_cpu_param: small register-file datapath with a valid/ready instruction
// port. Most ops complete in one cycle. MUL runs a WIDTH-step shift-add
// sequence, and in_ready is held low while it runs.
//
// Ports:
//   clock      single clock; all state changes on its rising edge
//   reset      synchronous, active-high
//   in         instruction {op[3:0], dst[RA-1:0], src[RA-1:0], imm[WIDTH-1:0]}
//   in_valid   an instruction is present on in
//   in_ready   an instruction can be accepted (high only in IDLE)
//   out        result of the last completed op (registered)
//   out_valid  one-cycle pulse for each completed op
//   overflow   carry/borrow/high-product status of the last completed op
module mini_cpu_param #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int RA = $clog2(NREGS),
  localparam int IW = 4 + 2 * RA + WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IW-1:0]    in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_CLR = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_XOR = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_MUL = 4'hB;

  typedef enum logic {IDLE, S_MUL} state_t;

  state_t state;

  logic [WIDTH-1:0]   regs [NREGS];
  logic [2*WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [2*WIDTH-1:0] mul_acc;
  logic [CW-1:0]      mul_count;
  logic [RA-1:0]      mul_dst;

  // Instruction fields
  logic [3:0]       op;
  logic [RA-1:0]    dst;
  logic [RA-1:0]    src;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] d_val;
  logic [WIDTH-1:0] s_val;

  assign op    = in[IW-1 -: 4];
  assign dst   = in[WIDTH+2*RA-1 -: RA];
  assign src   = in[WIDTH+RA-1 -: RA];
  assign imm   = in[WIDTH-1:0];
  assign d_val = regs[dst];
  assign s_val = regs[src];

  assign in_ready = (state == IDLE);

  // Single-cycle ALU
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_wr;
  logic             alu_done;

  assign sum_ext  = {1'b0, d_val} + {1'b0, s_val};
  assign diff_ext = {1'b0, d_val} - {1'b0, s_val};

  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_wr   = 1'b0;
    alu_done = 1'b1;
    case (op)
      OP_CLR: alu_res = '0;
      OP_LDI: begin alu_res = imm;                 alu_wr = 1'b1; end
      OP_MOV: begin alu_res = s_val;               alu_wr = 1'b1; end
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_ovf = sum_ext[WIDTH];
        alu_wr  = 1'b1;
      end
      OP_SUB: begin
        // The top bit of the extended difference is the borrow.
        alu_res = diff_ext[WIDTH-1:0];
        alu_ovf = diff_ext[WIDTH];
        alu_wr  = 1'b1;
      end
      OP_SHL: begin
        alu_res = {s_val[WIDTH-2:0], 1'b0};
        alu_ovf = s_val[WIDTH-1];
        alu_wr  = 1'b1;
      end
      OP_SHR: begin alu_res = {1'b0, s_val[WIDTH-1:1]}; alu_wr = 1'b1; end
      OP_AND: begin alu_res = d_val & s_val;       alu_wr = 1'b1; end
      OP_OR:  begin alu_res = d_val | s_val;       alu_wr = 1'b1; end
      OP_XOR: begin alu_res = d_val ^ s_val;       alu_wr = 1'b1; end
      OP_CMP: alu_res = {{(WIDTH-2){1'b0}}, (d_val > s_val), (d_val == s_val)};
      default: alu_done = 1'b0;  // MUL completes later; 1100-1111 are NOPs
    endcase
  end

  // One shift-add step. The completing step folds its own add in.
  logic [2*WIDTH-1:0] acc_next;
  assign acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      out        <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_acc    <= '0;
      mul_count  <= '0;
      mul_dst    <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_CLR) begin
              for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            end
            if (alu_wr) regs[dst] <= alu_res;
            if (alu_done) begin
              out       <= alu_res;
              overflow  <= alu_ovf;
              out_valid <= 1'b1;
            end
            if (op == OP_MUL) begin
              state      <= S_MUL;
              mul_mcand  <= {{WIDTH{1'b0}}, d_val};
              mul_mplier <= s_val;
              mul_acc    <= '0;
              mul_count  <= CW'(WIDTH);
              mul_dst    <= dst;
            end
          end
        end
        S_MUL: begin
          mul_acc    <= acc_next;
          mul_mcand  <= {mul_mcand[2*WIDTH-2:0], 1'b0};
          mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
          mul_count  <= mul_count - CW'(1);
          if (mul_count == CW'(1)) begin
            regs[mul_dst] <= acc_next[WIDTH-1:0];
            out           <= acc_next[WIDTH-1:0];
            overflow      <= |acc_next[2*WIDTH-1:WIDTH];
            out_valid     <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_cpu_param.sv
// Testbench for mini_cpu_param (WIDTH=8, NREGS=4).
// The driver applies instructions and updates an arithmetic reference model
// when each one is accepted. It pushes the expected result and its expected
// completion cycle into a queue. A monitor pops from the queue on every
// out_valid.
module tb_mini_cpu_param;

  localparam int W  = 8;
  localparam int NR = 4;
  localparam int IWD = 4 + 2 * 2 + W;
  localparam int MASK = (1 << W) - 1;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [IWD-1:0] in = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   out;
  logic           out_valid;
  logic           overflow;

  mini_cpu_param #(.WIDTH(W), .NREGS(NR)) dut (
    .clock(clock), .reset(reset), .in(in), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int val;
    int ovf;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   model_r [NR];
  int   last_out = 0;
  int   last_acc = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: runs at the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("result cycle=%0d out=%0d ovf=%0d exp_out=%0d exp_ovf=%0d", cyc, out, overflow, e.val, e.ovf);
        check("out", int'(out), e.val);
        check("overflow", int'(overflow), e.ovf);
        check("completion_cycle", cyc, e.at);
      end
    end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      check("missing_out_valid", 0, 1);
      void'(exp_q.pop_front());
    end
  end

  // Reference model: applies one accepted instruction. A NOP pushes nothing.
  task automatic model(input int op, input int d, input int s, input int imm, input int acc);
    int dv, sv, r, o, t;
    dv = model_r[d];
    sv = model_r[s];
    r  = 0;
    o  = 0;
    t  = acc;
    case (op)
      0: for (int i = 0; i < NR; i++) model_r[i] = 0;
      1: r = imm;
      2: r = sv;
      3: begin r = (dv + sv) & MASK; o = (dv + sv > MASK); end
      4: begin r = (dv - sv) & MASK; o = (dv < sv); end
      5: begin r = (sv * 2) & MASK;  o = (sv >= (1 << (W - 1))); end
      6: r = sv / 2;
      7: r = dv & sv;
      8: r = dv | sv;
      9: r = dv ^ sv;
      10: r = (dv > sv) * 2 + (dv == sv);
      11: begin
        r = (dv * sv) % (1 << W);
        o = (dv * sv) >= (1 << W);
        t = acc + W;
      end
      default: return;
    endcase
    if (op >= 1 && op <= 9 || op == 11) model_r[d] = r;
    last_out = r;
    exp_q.push_back('{val: r, ovf: o, at: t});
  endtask

  // The caller is at a falling edge. This task leaves in_valid high and
  // returns at the falling edge after the accept edge.
  task automatic issue(input int op, input int d, input int s, input int imm);
    int n;
    in = {4'(op), 2'(d), 2'(s), 8'(imm)};
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    $display("issue cycle=%0d op=%0d dst=%0d src=%0d imm=%0d", last_acc, op, d, s, imm);
    model(op, d, s, imm, last_acc);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NR; i++) model_r[i] = 0;
    last_out = 0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < W + 4; i++) @(negedge clock);
  endtask

  int n_low, mul_acc_cyc;

  initial begin
    for (int i = 0; i < NR; i++) model_r[i] = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_out", int'(out), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_in_ready", int'(in_ready), 1);

    // Back-to-back basic ops
    issue(1, 1, 0, 7); issue(1, 2, 0, 8); issue(3, 1, 2, 0); idle();
    wait_idle();
    // Carry, shifts
    issue(1, 1, 0, 135); issue(1, 2, 0, 136); issue(3, 1, 2, 0);
    issue(5, 3, 2, 0); issue(6, 3, 2, 0); idle();
    wait_idle();

    // MUL timing: in_ready stays low for WIDTH falling edges
    issue(1, 1, 0, 13); issue(1, 2, 0, 11); issue(11, 1, 2, 0); idle();
    n_low = 0;
    while (!in_ready && n_low < 40) begin
      n_low++;
      @(negedge clock);
    end
    check("mul_ready_low_cycles", n_low, W);
    wait_idle();
    issue(1, 1, 0, 20); issue(1, 2, 0, 20); issue(11, 1, 2, 0); idle();
    wait_idle();

    // CMP cases, then read back the registers to confirm they are unchanged
    issue(1, 1, 0, 7); issue(1, 2, 0, 8); issue(10, 1, 2, 0);
    issue(10, 2, 1, 0);
    issue(1, 3, 0, 9); issue(10, 3, 3, 0);
    issue(2, 0, 1, 0); issue(2, 0, 2, 0); idle();
    wait_idle();

    // Reset 4 cycles after a MUL is accepted
    issue(1, 1, 0, 50); issue(11, 1, 1, 0); idle();
    repeat (3) @(negedge clock);
    do_reset();
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out", int'(out), 0);
    check("abort_out_valid", int'(out_valid), 0);
    for (int i = 0; i < NR; i++) issue(2, i, i, 0);
    idle();
    wait_idle();

    // SUB queued behind a MUL, then a NOP
    issue(1, 1, 0, 5); issue(1, 2, 0, 7); issue(11, 3, 3, 0);
    mul_acc_cyc = last_acc;
    issue(4, 1, 2, 0);
    check("sub_accept_offset", last_acc - mul_acc_cyc, W + 1);
    issue(15, 1, 2, 0); idle();
    @(negedge clock);
    check("nop_out_hold", int'(out), last_out);
    wait_idle();

    // Random instruction stream
    for (int k = 0; k < 300; k++) begin
      int op;
      op = $urandom_range(0, 15);
      if (op == 0 && $urandom_range(0, 3) != 0) op = 1;
      issue(op, $urandom_range(0, NR - 1), $urandom_range(0, NR - 1), $urandom_range(0, MASK));
      if ($urandom_range(0, 4) == 0) begin
        idle();
        @(negedge clock);
      end
    end
    idle();
    wait_idle();
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
